mux8_1_rr: RTL and testbench

Round-robin 8:1 collector: the return-path counterpart of the 1:8 demultiplexer. Eight producer lanes, each with a valid/ready handshake, are merged onto one registered output lane. Each output word carries a 3-bit select, so a downstream `demux1_8` can route it back to the matching output. Fairness is round-robin, and with a continuously ready sink the block sustains one word per cycle.

---
 rtl/mux_demux_pkg.sv | 7 +
 rtl/rr_arbiter8.sv | 30 +++
 rtl/mux8_1_rr.sv | 71 +++++++
 tb/tb_mux8_1_rr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_demux_pkg.sv
// Shared lane-count and select types for the 1:8 demux and 8:1 round-robin collector.
package mux_demux_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin arbiter: first requesting lane at or after ptr, wrapping 7->0.
module rr_arbiter8
  import mux_demux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output sel_t            grant,
  output logic            any
);

  sel_t w_idx;
  logic w_found;

  // Rotating scan; the 3-bit add wraps the lane index naturally.
  always_comb begin
    grant   = ptr;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = ptr + sel_t'(k);
      if (!w_found && req[w_idx]) begin
        grant   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux8_1_rr.sv
// Round-robin 8:1 collector onto a one-entry registered output lane with select tag.
module mux8_1_rr
  import mux_demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]  r_state;
  logic [W-1:0] r_data;
  sel_t        r_sel;
  sel_t        r_ptr;

  sel_t        w_grant;
  logic        w_any;
  logic        w_load;
  logic [N_CH-1:0] w_in_ready;

  rr_arbiter8 u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  // Empty slot or a word leaving this cycle both free the register for refill.
  assign w_load = (r_state == S_EMPTY) || out_ready;

  always_comb begin
    w_in_ready = '0;
    if (w_load && w_any) begin
      w_in_ready[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_state <= S_FULL;
        r_data  <= in_data[w_grant*W +: W];
        r_sel   <= w_grant;
        r_ptr   <= w_grant + sel_t'(1);
      end else begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_mux8_1_rr.sv
// Directed + randomized bench for mux8_1_rr against a lane-scanning reference model.
module tb_mux8_1_rr;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_valid;
  logic [7:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  mux8_1_rr #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One clock: check at negedge, then advance the model on the rising edge.
  task automatic cycle(input string tag);
    int           g;
    int           taken;
    bit           ld;
    logic [7:0]   exp_rdy;
    logic [7:0]   y_got;
    logic [7:0]   y_exp;
    logic [2:0]   s;
    @(negedge clk);
    ld = !m_valid || out_ready;
    g  = pick(in_valid, m_ptr);
    exp_rdy = 8'h00;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;

    checks++;
    assert (out_valid === m_valid) else begin
      errors++;
      $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, m_valid);
    end
    checks++;
    assert (out_sel === 3'(m_sel)) else begin
      errors++;
      $error("FAIL %s out_sel got %0d exp %0d", tag, out_sel, m_sel);
    end
    checks++;
    assert (out_data === m_data) else begin
      errors++;
      $error("FAIL %s out_data got %0h exp %0h", tag, out_data, m_data);
    end
    checks++;
    assert (in_ready === exp_rdy) else begin
      errors++;
      $error("FAIL %s in_ready got %b exp %b", tag, in_ready, exp_rdy);
    end
    if (m_valid) begin
      // Loopback through a 1:8 demux: s0 = out_sel[2] is the MSB of the y-index.
      s = {out_sel[2], out_sel[1], out_sel[0]};
      y_got = 8'h00;
      y_got[s] = out_data[0];
      y_exp = 8'h00;
      y_exp[m_sel] = m_data[0];
      checks++;
      assert (y_got === y_exp) else begin
        errors++;
        $error("FAIL %s demux_y got %b exp %b", tag, y_got, y_exp);
      end
    end

    $display("[%0t] %s valid=%b rdy=%b out_v=%b sel=%0d data=%h",
             $time, tag, in_valid, in_ready, out_valid, out_sel, out_data);

    @(posedge clk);
    taken = -1;
    if (rst) begin
      model_reset();
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        m_ptr   = (g + 1) % 8;
        taken   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (taken >= 0) in_data[taken*W +: W] = W'($urandom);
  endtask

  initial begin
    model_reset();
    rst       = 1'b1;
    in_valid  = 8'h00;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    #1;

    // Reset then idle
    repeat (2) cycle("reset");
    rst = 1'b0;
    repeat (5) cycle("idle");

    // Full-load fairness: lane i presents i+8
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'(i + 8);
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'(i + 8);
      cycle("fair");
    end

    // Backpressure with lanes 2 and 5
    in_valid = 8'b0010_0100;
    cycle("bp_load");
    out_ready = 1'b0;
    repeat (3) cycle("bp_stall");
    out_ready = 1'b1;
    repeat (3) cycle("bp_release");

    // Wrap and skip: grant lane 5 alone to park ptr at 6, then lanes 1 and 6
    in_valid = 8'b0010_0000;
    cycle("wrap_prime");
    in_valid = 8'b0100_0010;
    repeat (3) cycle("wrap");

    // Drain to empty via lane 3
    in_valid = 8'h00;
    repeat (2) cycle("drain_idle");
    in_valid = 8'b0000_1000;
    cycle("drain_load");
    in_valid = 8'h00;
    repeat (3) cycle("drain");

    // Reset mid-stream while FULL with out_sel=4
    in_valid  = 8'b0001_0000;
    out_ready = 1'b0;
    repeat (2) cycle("mid_fill");
    rst = 1'b1;
    in_valid = 8'hFF;
    cycle("mid_rst");
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle("post_rst");

    // Randomized traffic with random backpressure and dropped requests
    for (int n = 0; n < 300; n++) begin
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
